// File: rtl/lcd_sequencer_if.sv
// Signal bundle between lcd_sequencer and its script ROM, frame buffer and LCD pins.
interface lcd_sequencer_if #(
  parameter int SIZE  = 4,
  parameter int ADDRW = 4
);
  logic [10:0]       i_comm;
  logic [SIZE*8-1:0] i_data;
  logic              i_start;
  logic [ADDRW-1:0]  o_addr;
  logic              o_RS;
  logic              o_RW;
  logic [7:0]        o_DB;
  logic              o_E;
  logic              o_busy;
  logic              o_frame;

  modport master (
    input  i_comm, i_data, i_start,
    output o_addr, o_RS, o_RW, o_DB, o_E, o_busy, o_frame
  );

  modport slave (
    output i_comm, i_data, i_start,
    input  o_addr, o_RS, o_RW, o_DB, o_E, o_busy, o_frame
  );
endinterface

// File: rtl/lcd_sequencer.sv
// HD44780-style LCD script sequencer with frame-buffer character substitution.
// Define LCD_NIBBLE_MODE_EN for a 4-bit bus (two E pulses per op on o_DB[7:4]).
module lcd_sequencer #(
  parameter int SIZE      = 4,
  parameter int ADDRW     = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int WAIT_CYC  = 4,
  parameter int LONG_CYC  = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  lcd_sequencer_if.master bus
);
  localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_B   = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > LONG_CYC) ? MAX_C : LONG_CYC;
  localparam int CNTW    = $clog2(MAX_CYC) + 1;

  localparam logic [CNTW-1:0] SETUP_LD = CNTW'(SETUP_CYC - 1);
  localparam logic [CNTW-1:0] PULSE_LD = CNTW'(PULSE_CYC - 1);
  localparam logic [CNTW-1:0] HOLD_LD  = CNTW'(HOLD_CYC - 1);
  localparam logic [CNTW-1:0] WAIT_LD  = CNTW'(WAIT_CYC - 1);
  localparam logic [CNTW-1:0] LONG_LD  = CNTW'(LONG_CYC - 1);

  localparam logic [1:0] OP_INSTR = 2'b00;
  localparam logic [1:0] OP_FB    = 2'b10;
  localparam logic [1:0] OP_LOOP  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, SETUP, PULSE, HOLD, SETTLE
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [ADDRW-1:0]  addr_q, addr_d;
  logic              rs_q, rs_d;
  logic [7:0]        db_q, db_d;
  logic              e_q, e_d;
  logic              busy_q, busy_d;
  logic              frame_q, frame_d;
  logic              long_q, long_d;
  logic [SIZE*8-1:0] snap_q, snap_d;
`ifdef LCD_NIBBLE_MODE_EN
  logic              nib_q, nib_d;
  logic [7:0]        byte_q, byte_d;
`endif

  logic [1:0] op;
  logic [7:0] fb_chr;
  logic [7:0] op_chr;
  logic [7:0] snap_chars [SIZE];

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_char
    assign snap_chars[gi] = snap_q[8*gi +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rs_d    = rs_q;
    db_d    = db_q;
    e_d     = e_q;
    busy_d  = busy_q;
    frame_d = 1'b0;
    long_d  = long_q;
    snap_d  = snap_q;
`ifdef LCD_NIBBLE_MODE_EN
    nib_d   = nib_q;
    byte_d  = byte_q;
`endif
    op      = bus.i_comm[10:9];
    // Operands past the end of the frame buffer render as a blank.
    fb_chr  = 8'h20;
    for (int k = 0; k < SIZE; k++) begin
      if (bus.i_comm[7:0] == 8'(k)) fb_chr = snap_chars[k];
    end
    op_chr  = (op == OP_FB) ? fb_chr : bus.i_comm[7:0];

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          addr_d  = '0;
          snap_d  = bus.i_data;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (op == OP_LOOP) begin
          addr_d  = ADDRW'(bus.i_comm[7:0]);
          snap_d  = bus.i_data;
          frame_d = 1'b1;
          state_d = FETCH;
        end else begin
          rs_d    = (op != OP_INSTR);
          long_d  = bus.i_comm[8];
          cnt_d   = SETUP_LD;
          state_d = SETUP;
`ifdef LCD_NIBBLE_MODE_EN
          nib_d   = 1'b0;
          byte_d  = op_chr;
          db_d    = {op_chr[7:4], 4'h0};
`else
          db_d    = op_chr;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          e_d     = 1'b1;
          cnt_d   = PULSE_LD;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          e_d     = 1'b0;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = long_q ? LONG_LD : WAIT_LD;
          state_d = SETTLE;
`ifdef LCD_NIBBLE_MODE_EN
          // Low nibble gets its own full bus cycle before settling.
          if (!nib_q) begin
            nib_d   = 1'b1;
            db_d    = {byte_q[3:0], 4'h0};
            cnt_d   = SETUP_LD;
            state_d = SETUP;
          end
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          addr_d  = addr_q + 1'b1;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rs_q    <= 1'b0;
      db_q    <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      frame_q <= 1'b0;
      long_q  <= 1'b0;
      snap_q  <= '0;
`ifdef LCD_NIBBLE_MODE_EN
      nib_q   <= 1'b0;
      byte_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      frame_q <= frame_d;
      long_q  <= long_d;
      snap_q  <= snap_d;
`ifdef LCD_NIBBLE_MODE_EN
      nib_q   <= nib_d;
      byte_q  <= byte_d;
`endif
    end
  end

  assign bus.o_addr  = addr_q;
  assign bus.o_RS    = rs_q;
  assign bus.o_RW    = 1'b0;
  assign bus.o_DB    = db_q;
  assign bus.o_E     = e_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_frame = frame_q;
endmodule
